alu_multicycle: RTL and testbench

//  Next-generation CPU ALU: parametrised width, registered results, start/done handshake.

---
 rtl/alu_multicycle.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: registered result and status flags, start/done handshake,
// iterative shift-add multiply and restoring divide sharing one hi/lo register pair.
module alu_multicycle #(
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    equal,
  output logic                    less,
  output logic                    greater,
  output logic                    zero,
  output logic                    carry,
  output logic                    negative,
  output logic                    overflow,
  output logic                    div_zero
);

  localparam int SW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_ADD = OPCODE_WIDTH'(0),  OP_SUB = OPCODE_WIDTH'(1),  OP_MUL = OPCODE_WIDTH'(2),
    OP_AND = OPCODE_WIDTH'(3),  OP_OR  = OPCODE_WIDTH'(4),  OP_XOR = OPCODE_WIDTH'(5),
    OP_NOT = OPCODE_WIDTH'(6),  OP_NEG = OPCODE_WIDTH'(7),  OP_CMP = OPCODE_WIDTH'(8),
    OP_DIV = OPCODE_WIDTH'(9),  OP_MOD = OPCODE_WIDTH'(10), OP_SHL = OPCODE_WIDTH'(11),
    OP_SHR = OPCODE_WIDTH'(12), OP_ASR = OPCODE_WIDTH'(13)
  } op_t;

  state_t                state_q, state_d;
  op_t                   op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [SW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  done_q, equal_q, less_q, greater_q;
  logic                  zero_q, carry_q, negative_q, overflow_q, div_zero_q;

  logic                  accept, fin, last_step;
  op_t                   op_in;

  logic [DATA_WIDTH:0]   mul_sum, div_trial, div_diff;
  logic                  div_bit;
  logic [DATA_WIDTH-1:0] div_rem;

  logic [DATA_WIDTH:0]   add_full, sub_full, neg_full, shl_full, shr_full, asr_full;
  logic [SW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] res_d;
  logic                  carry_d, overflow_d, div_zero_d, wr_main, wr_cmp;

  assign op_in     = op_t'(opcode);
  assign last_step = (cnt_q == SW'(DATA_WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) begin
        if (op_in == OP_MUL)                         state_d = MUL;
        else if (op_in == OP_DIV || op_in == OP_MOD) state_d = DIV;
        else                                         state_d = FIN;
      end
      MUL:     if (last_step) state_d = FIN;
      DIV:     if (last_step) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = (state_q != IDLE);
    accept = (state_q == IDLE) && start;
    fin    = (state_q == FIN);
  end

  // Multiply: hi accumulates, lo holds the multiplier and collects product low bits.
  // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_trial = {hi_q, lo_q[DATA_WIDTH-1]};
    div_diff  = div_trial - {1'b0, b_q};
    div_bit   = (div_trial >= {1'b0, b_q});
    div_rem   = div_bit ? div_diff[DATA_WIDTH-1:0] : div_trial[DATA_WIDTH-1:0];
  end

  // Single-cycle ops; the extra bit of each *_full carries the carry/borrow/shifted-out bit
  always_comb begin
    shamt    = b_q[SW-1:0];
    add_full = {1'b0, a_q} + {1'b0, b_q};
    sub_full = {1'b0, a_q} - {1'b0, b_q};
    neg_full = {(DATA_WIDTH+1){1'b0}} - {1'b0, a_q};
    shl_full = {1'b0, a_q} << shamt;
    shr_full = {a_q, 1'b0} >> shamt;
    asr_full = $unsigned($signed({a_q, 1'b0}) >>> shamt);

    res_d      = result_q;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    div_zero_d = 1'b0;
    wr_main    = 1'b1;
    wr_cmp     = 1'b0;
    case (op_q)
      OP_ADD: begin
        {carry_d, res_d} = add_full;
        overflow_d = (a_q[DATA_WIDTH-1] == b_q[DATA_WIDTH-1]) &&
                     (res_d[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        {carry_d, res_d} = sub_full;
        overflow_d = (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &&
                     (res_d[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
      end
      OP_MUL: begin
        res_d      = lo_q;
        overflow_d = |hi_q;
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      OP_NOT: res_d = ~a_q;
      OP_NEG: begin
        {carry_d, res_d} = neg_full;
        overflow_d = a_q[DATA_WIDTH-1] && res_d[DATA_WIDTH-1];
      end
      OP_CMP: begin
        wr_main = 1'b0;
        wr_cmp  = 1'b1;
      end
      OP_DIV: begin
        res_d      = lo_q;
        div_zero_d = (b_q == '0);
      end
      OP_MOD: begin
        res_d      = hi_q;
        div_zero_d = (b_q == '0);
      end
      OP_SHL: {carry_d, res_d} = shl_full;
      OP_SHR: {res_d, carry_d} = shr_full;
      OP_ASR: {res_d, carry_d} = asr_full;
      default: wr_main = 1'b0;
    endcase
  end

  // Datapath and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      equal_q    <= 1'b0;
      less_q     <= 1'b0;
      greater_q  <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (accept) begin
        op_q  <= op_in;
        a_q   <= op_a;
        b_q   <= op_b;
        cnt_q <= '0;
        hi_q  <= '0;
        lo_q  <= (op_in == OP_DIV || op_in == OP_MOD) ? op_a : op_b;
      end else if (state_q == MUL) begin
        hi_q  <= mul_sum[DATA_WIDTH:1];
        lo_q  <= {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
        cnt_q <= cnt_q + SW'(1);
      end else if (state_q == DIV) begin
        hi_q  <= div_rem;
        lo_q  <= {lo_q[DATA_WIDTH-2:0], div_bit};
        cnt_q <= cnt_q + SW'(1);
      end
      if (fin && wr_main) begin
        result_q   <= res_d;
        zero_q     <= (res_d == '0);
        negative_q <= res_d[DATA_WIDTH-1];
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
        div_zero_q <= div_zero_d;
      end
      if (fin && wr_cmp) begin
        equal_q   <= (a_q == b_q);
        less_q    <= (a_q <  b_q);
        greater_q <= (a_q >  b_q);
      end
    end
  end

  assign done     = done_q;
  assign result   = result_q;
  assign equal    = equal_q;
  assign less     = less_q;
  assign greater  = greater_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign negative = negative_q;
  assign overflow = overflow_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: stimulus pushes hand-computed results,
// a monitor pops and compares on every done pulse.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [15:0] op_a = '0, op_b = '0;
  logic        busy, done, equal, less, greater, zero, carry, negative, overflow, div_zero;
  logic [15:0] result;

  alu_multicycle #(.DATA_WIDTH(16), .OPCODE_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .equal(equal), .less(less),
    .greater(greater), .zero(zero), .carry(carry), .negative(negative),
    .overflow(overflow), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] res;
    logic [7:0]  fl;   // {eq,lt,gt,z,c,n,v,dz}
    int          lat;
    int          t0;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  wire [7:0] dut_fl = {equal, less, greater, zero, carry, negative, overflow, div_zero};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, "_result"}, 32'(result), 32'(e.res));
        chk({e.nm, "_flags"},  32'(dut_fl), 32'(e.fl));
        chk({e.nm, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic drive(input bit sync, input bit push, input string nm, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] er, input logic [7:0] ef, input int lat);
    exp_t e;
    if (sync) @(negedge clk);
    start  = 1'b1;
    opcode = op;
    op_a   = a;
    op_b   = b;
    if (push) begin
      e.nm = nm; e.res = er; e.fl = ef; e.lat = lat; e.t0 = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending expected 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic run(input string nm, input logic [3:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] er, input logic [7:0] ef,
                     input int lat);
    drive(1'b1, 1'b1, nm, op, a, b, er, ef, lat);
    drain(nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, result, dut_fl}, '0);
    rst_n = 1'b1;

    run("add_wrap", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 8'b000_11000, 2);

    // MUL with busy-cycle count and an ignored start mid-op
    drive(1'b1, 1'b1, "mul_ovf", 4'h2, 16'h0100, 16'h0100, 16'h0000, 8'b000_10010, 18);
    nb = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) break;
      if (busy) nb++;
      if (i == 4) begin
        start = 1'b1; opcode = 4'h0; op_a = 16'h0001; op_b = 16'h0001;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("mul_busy_cycles", 32'(nb), 32'd17);
    chk("mul_busy_at_done", 32'(busy), 32'd0);
    drain("mul_ovf");

    run("div",      4'h9, 16'd100,  16'd7,    16'h000E, 8'b000_00000, 18);
    run("mod",      4'hA, 16'd100,  16'd7,    16'h0002, 8'b000_00000, 18);
    run("div_zero", 4'h9, 16'd5,    16'd0,    16'hFFFF, 8'b000_00101, 18);
    run("add_clr",  4'h0, 16'd1,    16'd2,    16'h0003, 8'b000_00000, 2);
    run("cmp_lt",   4'h8, 16'd3,    16'd9,    16'h0003, 8'b010_00000, 2);
    run("xor",      4'h5, 16'h00F0, 16'h0FF0, 16'h0F00, 8'b010_00000, 2);
    run("asr",      4'hD, 16'h8000, 16'd4,    16'hF800, 8'b010_00100, 2);
    run("shl",      4'hB, 16'h8001, 16'd1,    16'h0002, 8'b010_01000, 2);
    run("sub_ovf",  4'h1, 16'h8000, 16'h0001, 16'h7FFF, 8'b010_00010, 2);
    run("undef_e",  4'hE, 16'h1234, 16'h0000, 16'h7FFF, 8'b010_00010, 2);
    run("cmp_eq",   4'h8, 16'd5,    16'd5,    16'h7FFF, 8'b100_00010, 2);

    // start issued in the same cycle as the previous done
    drive(1'b1, 1'b1, "b2b_and", 4'h3, 16'hF0F0, 16'h0FF0, 16'h00F0, 8'b100_00000, 2);
    @(negedge clk);
    chk("b2b_done_seen", 32'(done), 32'd1);
    drive(1'b0, 1'b1, "b2b_or", 4'h4, 16'h1200, 16'h0034, 16'h1234, 8'b100_00000, 2);
    drain("b2b");

    run("mul_small", 4'h2, 16'h0012, 16'h0034, 16'h03A8, 8'b100_00000, 18);
    run("shr",       4'hC, 16'h0003, 16'd1,    16'h0001, 8'b100_01000, 2);
    run("sub_borrow", 4'h1, 16'h0001, 16'h0002, 16'hFFFF, 8'b100_01100, 2);

    // Asynchronous reset in the fifth MUL cycle: op aborted, no done afterwards
    drive(1'b1, 1'b0, "mul_abort", 4'h2, 16'h0003, 16'h0003, 16'h0000, 8'h00, 0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_outputs", {busy, done, result, dut_fl}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_idle", {busy, done}, '0);

    run("add_after_rst", 4'h0, 16'd2, 16'd3, 16'h0005, 8'b000_00000, 2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
